// File: rtl/issue_decode.sv
// Decode/issue stage: RV32I-subset decode, 32x32 regfile with writeback forwarding, busy-bit hazard scoreboard.
// Latency: an instruction accepted on edge N is presented to EXE right after edge N from a one-entry output register.
// Backpressure: io_instReady_ID drops on an unresolved source hazard or while EXE holds a valid output unconsumed.
module issue_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_inst_ID,
    input  logic        io_instValid_ID,
    output logic        io_instReady_ID,
    output logic [3:0]  io_aluOP_ctrl_uEXE_ID,
    output logic [31:0] io_data1_ID,
    output logic [31:0] io_data2_ID,
    output logic [31:0] io_storeData_ID,
    output logic [4:0]  io_rd_ID,
    output logic        io_wen_ID,
    output logic        io_illegal_ID,
    output logic        io_valid_ID,
    input  logic        io_ready_EXE,
    input  logic        io_wbEn,
    input  logic [4:0]  io_wbAddr,
    input  logic [31:0] io_wbData
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SRL = 4'h2;
    localparam logic [3:0] ALU_SRA = 4'h3;
    localparam logic [3:0] ALU_MEM = 4'h8;
    localparam logic [3:0] ALU_SLT = 4'h9;

    // Selects where operand 2 comes from.
    typedef enum logic [1:0] {
        OP2_RS2   = 2'd0,
        OP2_IMM_I = 2'd1,
        OP2_SHAMT = 2'd2,
        OP2_IMM_S = 2'd3
    } op2_sel_t;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_shamt;

    assign opcode    = io_inst_ID[6:0];
    assign rd        = io_inst_ID[11:7];
    assign funct3    = io_inst_ID[14:12];
    assign rs1       = io_inst_ID[19:15];
    assign rs2       = io_inst_ID[24:20];
    assign funct7    = io_inst_ID[31:25];
    assign imm_i     = {{20{io_inst_ID[31]}}, io_inst_ID[31:20]};
    assign imm_s     = {{20{io_inst_ID[31]}}, io_inst_ID[31:25], io_inst_ID[11:7]};
    // Shift-immediates carry funct7 in the upper imm bits; only the shamt is a real operand.
    assign imm_shamt = {27'd0, io_inst_ID[24:20]};

    // Decode results
    logic       dec_legal;
    logic [3:0] dec_aluop;
    logic       dec_use_rs2;
    logic       dec_is_store;
    logic       dec_writes;
    op2_sel_t   dec_op2_sel;
    logic       dec_wen;

    // Architectural state
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Output register
    logic        valid_q,   valid_d;
    logic [3:0]  aluop_q,   aluop_d;
    logic [31:0] data1_q,   data1_d;
    logic [31:0] data2_q,   data2_d;
    logic [31:0] sdata_q,   sdata_d;
    logic [4:0]  rd_q,      rd_d;
    logic        wen_q,     wen_d;
    logic        illegal_q, illegal_d;

    // Operand read / hazard signals
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        rs1_hazard;
    logic        rs2_hazard;
    logic        stall;
    logic        accept;
    logic [31:0] op2_val;

    // Map opcode/funct3/funct7 to ALU op, operand-2 source and register usage.
    always_comb begin
        dec_legal    = 1'b0;
        dec_aluop    = ALU_NOP;
        dec_use_rs2  = 1'b0;
        dec_is_store = 1'b0;
        dec_writes   = 1'b0;
        dec_op2_sel  = OP2_RS2;
        unique case (opcode)
            OPC_OP: begin
                dec_use_rs2 = 1'b1;
                dec_writes  = 1'b1;
                dec_op2_sel = OP2_RS2;
                if (funct3 == 3'b000 && funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_ADD;
                end else if (funct3 == 3'b101 && funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_SRL;
                end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_SRA;
                end else if (funct3 == 3'b010 && funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_SLT;
                end
            end
            OPC_OP_IMM: begin
                dec_writes  = 1'b1;
                dec_op2_sel = OP2_IMM_I;
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_ADD;
                end else if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_SLT;
                end else if (funct3 == 3'b101 && funct7 == F7_BASE) begin
                    dec_legal   = 1'b1;
                    dec_aluop   = ALU_SRL;
                    dec_op2_sel = OP2_SHAMT;
                end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    dec_legal   = 1'b1;
                    dec_aluop   = ALU_SRA;
                    dec_op2_sel = OP2_SHAMT;
                end
            end
            OPC_LOAD: begin
                dec_writes  = 1'b1;
                dec_op2_sel = OP2_IMM_I;
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_MEM;
                end
            end
            OPC_STORE: begin
                dec_use_rs2  = 1'b1;
                dec_is_store = 1'b1;
                dec_op2_sel  = OP2_IMM_S;
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_aluop = ALU_MEM;
                end
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Writing x0 is architecturally a no-op, so it never claims a busy bit.
    assign dec_wen = dec_legal && dec_writes && (rd != 5'd0);

    // Operand read with same-cycle writeback bypass; x0 is hardwired to zero.
    always_comb begin
        rs1_fwd = io_wbEn && (io_wbAddr == rs1) && (rs1 != 5'd0);
        rs2_fwd = io_wbEn && (io_wbAddr == rs2) && (rs2 != 5'd0);
        if (rs1 == 5'd0) begin
            rs1_val = 32'd0;
        end else if (rs1_fwd) begin
            rs1_val = io_wbData;
        end else begin
            rs1_val = rf_q[rs1];
        end
        if (rs2 == 5'd0) begin
            rs2_val = 32'd0;
        end else if (rs2_fwd) begin
            rs2_val = io_wbData;
        end else begin
            rs2_val = rf_q[rs2];
        end
    end

    // Operand-2 selection.
    always_comb begin
        op2_val = 32'd0;
        unique case (dec_op2_sel)
            OP2_RS2:   op2_val = rs2_val;
            OP2_IMM_I: op2_val = imm_i;
            OP2_SHAMT: op2_val = imm_shamt;
            OP2_IMM_S: op2_val = imm_s;
            default:   op2_val = 32'd0;
        endcase
    end

    // Hazard detection: a busy source is only safe when its writeback lands this cycle.
    always_comb begin
        rs1_hazard = dec_legal && busy_q[rs1] && !rs1_fwd;
        rs2_hazard = dec_legal && dec_use_rs2 && busy_q[rs2] && !rs2_fwd;
        stall      = rs1_hazard || rs2_hazard;
    end

    assign io_instReady_ID = !stall && (!valid_q || io_ready_EXE);
    assign accept          = io_instValid_ID && io_instReady_ID;

    // Register file update from writeback; x0 stays zero.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (io_wbEn && (io_wbAddr != 5'd0)) begin
            rf_d[io_wbAddr] = io_wbData;
        end
    end

    // Busy scoreboard: writeback clears first so a same-cycle set on issue wins.
    always_comb begin
        busy_d = busy_q;
        if (io_wbEn) begin
            busy_d[io_wbAddr] = 1'b0;
        end
        if (accept && dec_wen) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output register: load on accept, drain when EXE consumes, otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        aluop_d   = aluop_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        sdata_d   = sdata_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        illegal_d = illegal_q;
        if (accept) begin
            valid_d   = 1'b1;
            aluop_d   = dec_aluop;
            data1_d   = dec_legal ? rs1_val : 32'd0;
            data2_d   = dec_legal ? op2_val : 32'd0;
            sdata_d   = (dec_legal && dec_is_store) ? rs2_val : 32'd0;
            rd_d      = rd;
            wen_d     = dec_wen;
            illegal_d = !dec_legal;
        end else if (io_ready_EXE) begin
            valid_d   = 1'b0;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
            busy_q    <= 32'd0;
            valid_q   <= 1'b0;
            aluop_q   <= ALU_NOP;
            data1_q   <= 32'd0;
            data2_q   <= 32'd0;
            sdata_q   <= 32'd0;
            rd_q      <= 5'd0;
            wen_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            sdata_q   <= sdata_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            illegal_q <= illegal_d;
        end
    end

    assign io_valid_ID           = valid_q;
    assign io_aluOP_ctrl_uEXE_ID = aluop_q;
    assign io_data1_ID           = data1_q;
    assign io_data2_ID           = data2_q;
    assign io_storeData_ID       = sdata_q;
    assign io_rd_ID              = rd_q;
    assign io_wen_ID             = wen_q;
    assign io_illegal_ID         = illegal_q;

endmodule
